// File: rtl/alu_mult_sequencer.sv
// Iterative unsigned shift-add multiplier that time-shares an external 32-bit ALU.
// Each RUN cycle presents acc + mcand to the ALU and keeps the sum when the multiplier LSB is set.
module alu_mult_sequencer #(
   parameter int unsigned WIDTH    = 16,
   parameter logic [3:0]  ALU_ADD  = 4'b0010,
   parameter logic [3:0]  ALU_IDLE = 4'b0000
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 start,
   input  logic [WIDTH-1:0]     a_in,
   input  logic [WIDTH-1:0]     b_in,
   output logic                 busy,
   output logic                 done,
   output logic [2*WIDTH-1:0]   product,
   output logic [3:0]           alu_ctl,
   output logic [31:0]          alu_a,
   output logic [31:0]          alu_b,
   input  logic [31:0]          alu_out
);

   localparam int unsigned     CW   = $clog2(WIDTH + 1);
   localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;

   state_t           state;
   state_t           state_next;
   logic [31:0]      acc;
   logic [31:0]      mcand;
   logic [WIDTH-1:0] mplier;
   logic [CW-1:0]    count;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clock) begin
      if (reset) state <= S_IDLE;
      else       state <= state_next;
   end

   // NOTE: every output gets a default before the case so no path leaves a latch behind.
   always_comb begin
      state_next = state;
      busy       = 1'b0;
      done       = 1'b0;
      alu_ctl    = ALU_IDLE;
      alu_a      = 32'd0;
      alu_b      = 32'd0;
      case (state)
         S_IDLE: begin
            if (start) state_next = S_RUN;
         end
         S_RUN: begin
            busy    = 1'b1;
            alu_ctl = ALU_ADD;
            alu_a   = acc;
            alu_b   = mcand;
            if (count == LAST) state_next = S_DONE;
         end
         S_DONE: begin
            busy       = 1'b1;
            done       = 1'b1;
            state_next = S_IDLE;
         end
         default: state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         acc    <= 32'd0;
         mcand  <= 32'd0;
         mplier <= '0;
         count  <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  acc    <= 32'd0;
                  mcand  <= 32'(a_in);
                  mplier <= b_in;
                  count  <= '0;
               end
            end
            S_RUN: begin
               // The ALU result is only the next partial sum when this multiplier bit is set.
               if (mplier[0]) acc <= alu_out;
               mcand  <= mcand << 1;
               mplier <= mplier >> 1;
               count  <= count + CW'(1);
            end
            default: ;
         endcase
      end
   end

   assign product = acc[2*WIDTH-1:0];

endmodule

// File: tb/tb_alu_mult_sequencer.sv
// Bench for alu_mult_sequencer: cycle-timed arithmetic model checked every cycle,
// plus directed multiplies with hand-computed products and latency.
module tb_alu_mult_sequencer;

   localparam int W = 16;

   logic          clock = 1'b0;
   logic          reset;
   logic          start;
   logic [W-1:0]  a_in;
   logic [W-1:0]  b_in;
   logic          busy;
   logic          done;
   logic [2*W-1:0] product;
   logic [3:0]    alu_ctl;
   logic [31:0]   alu_a;
   logic [31:0]   alu_b;
   logic [31:0]   alu_out;

   int vectors     = 0;
   int miscompares = 0;

   alu_mult_sequencer #(.WIDTH(W)) dut (
      .clock   (clock),
      .reset   (reset),
      .start   (start),
      .a_in    (a_in),
      .b_in    (b_in),
      .busy    (busy),
      .done    (done),
      .product (product),
      .alu_ctl (alu_ctl),
      .alu_a   (alu_a),
      .alu_b   (alu_b),
      .alu_out (alu_out)
   );

   always #5 clock = ~clock;

   // Stand-in for the MIPS ALU.
   always_comb begin
      case (alu_ctl)
         4'b0000: alu_out = alu_a & alu_b;
         4'b0001: alu_out = alu_a | alu_b;
         4'b0010: alu_out = alu_a + alu_b;
         4'b0110: alu_out = alu_a - alu_b;
         default: alu_out = 32'd0;
      endcase
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: a start accepted at an edge opens a window of W RUN cycles then one DONE cycle.
   // In RUN cycle k the ALU sees a*(b mod 2^(k-1)) and a*2^(k-1).
   bit          m_valid  = 1'b0;
   bit          m_active = 1'b0;
   int          m_k      = 0;
   logic [W-1:0] m_a, m_b;
   logic [31:0] m_prod   = 32'd0;

   always begin : model
      int j;
      @(posedge clock);
      if (reset) begin
         m_valid  = 1'b1;
         m_active = 1'b0;
         m_k      = 0;
         m_prod   = 32'd0;
      end else if (m_active) begin
         if (m_k == W + 1) begin
            m_active = 1'b0;
            m_prod   = 32'(m_a) * 32'(m_b);
         end else begin
            m_k++;
         end
      end else if (start) begin
         m_active = 1'b1;
         m_k      = 1;
         m_a      = a_in;
         m_b      = b_in;
      end
      @(negedge clock);
      if (m_valid) begin
         check("m_busy", 32'(busy), 32'(m_active));
         check("m_done", 32'(done), 32'(m_active && m_k == W + 1));
         if (m_active && m_k <= W) begin
            j = m_k - 1;
            check("m_run_ctl", 32'(alu_ctl), 32'h2);
            check("m_run_b", alu_b, 32'(m_a) << j);
            check("m_run_a", alu_a, 32'(m_a) * (32'(m_b) & ((32'd1 << j) - 32'd1)));
         end else begin
            check("m_ctl", 32'(alu_ctl), 32'h0);
            check("m_a", alu_a, 32'd0);
            check("m_b", alu_b, 32'd0);
            if (m_active) check("m_prod_done", product, 32'(m_a) * 32'(m_b));
            else          check("m_prod_held", product, m_prod);
         end
      end
   end

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   // One multiply with literal expectations; optional ignored starts at RUN cycle poke_run and in DONE.
   task automatic run_mult(input logic [W-1:0] a, input logic [W-1:0] b, input logic [31:0] exp,
                           input int poke_run, input bit poke_done, input string tag);
      int n;
      a_in  = a;
      b_in  = b;
      start = 1'b1;
      tick;
      start = 1'b0;
      check({tag, "_busy_after_start"}, 32'(busy), 32'd1);
      n = 1;
      while (!done && n < 40) begin
         if (n == poke_run) begin
            start = 1'b1;
            a_in  = 2;
            b_in  = 2;
         end
         tick;
         start = 1'b0;
         n++;
      end
      check({tag, "_latency"}, 32'(n), 32'd17);
      check({tag, "_product"}, product, exp);
      if (poke_done) begin
         start = 1'b1;
         a_in  = 2;
         b_in  = 2;
      end
      tick;
      start = 1'b0;
      check({tag, "_idle_busy"}, 32'(busy), 32'd0);
      check({tag, "_idle_done"}, 32'(done), 32'd0);
      check({tag, "_idle_product"}, product, exp);
      check({tag, "_idle_ctl"}, 32'(alu_ctl), 32'h0);
   endtask

   initial begin
      int n;
      reset = 1'b1;
      start = 1'b0;
      a_in  = '0;
      b_in  = '0;
      tick;
      tick;
      reset = 1'b0;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_product", product, 32'd0);
      check("rst_ctl", 32'(alu_ctl), 32'h0);
      check("rst_alu_a", alu_a, 32'd0);
      check("rst_alu_b", alu_b, 32'd0);

      run_mult(16'd3, 16'd5, 32'h0000_000F, 0, 1'b0, "3x5");
      run_mult(16'hFFFF, 16'hFFFF, 32'hFFFE_0001, 0, 1'b0, "max");
      run_mult(16'h0000, 16'h1234, 32'd0, 0, 1'b0, "zero_a");
      run_mult(16'h1234, 16'h0000, 32'd0, 0, 1'b0, "zero_b");
      run_mult(16'd7, 16'd9, 32'h0000_003F, 4, 1'b1, "ignore");

      // Reset in RUN cycle 6 discards the operation.
      a_in  = 16'h00FF;
      b_in  = 16'h0101;
      start = 1'b1;
      tick;
      start = 1'b0;
      n = 1;
      while (n < 6) begin
         tick;
         n++;
      end
      reset = 1'b1;
      tick;
      reset = 1'b0;
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_done", 32'(done), 32'd0);
      check("abort_product", product, 32'd0);
      n = 0;
      repeat (20) begin
         tick;
         if (done) n++;
      end
      check("abort_no_done", 32'(n), 32'd0);
      run_mult(16'h00FF, 16'h0101, 32'h0000_FFFF, 0, 1'b0, "after_abort");

      run_mult(16'd12, 16'd12, 32'h0000_0090, 0, 1'b0, "b2b_first");
      run_mult(16'h8000, 16'd2, 32'h0001_0000, 0, 1'b0, "b2b_second");

      repeat (3) tick;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish by %0t", $time);
      $fatal(1, "watchdog");
   end

endmodule
